// File: rtl/unified_mem_arbiter.sv
// -----------------------------------------------------------------------------
// unified_mem_arbiter
//
// Shares one single-ported unified memory between the instruction-fetch port
// and the load/store port of the RISC-V core. Each access walks through
// IDLE -> ISSUE -> (WAIT) -> RESP, so at most one transaction is outstanding.
// Data accesses win over fetch, except that after STARVE_MAX consecutive data
// grants taken while fetch was waiting, the next contested grant goes to fetch.
//
// Parameters
//   MEM_LAT    : cycles from accepted read (mem_en & mem_ready) to valid
//                mem_rdata, 1..7
//   STARVE_MAX : consecutive contested data grants before fetch is forced, 1..15
//
// Ports
//   clk, rst              : clock, synchronous active-high reset
//   if_req/if_addr        : fetch request (level) and address
//   if_rdata/if_valid     : fetch read data and one-cycle completion pulse
//   if_stall              : if_req & ~if_valid
//   d_req/d_addr          : data request (level) and address
//   d_wr/d_wdata          : byte write enables (0 = read) and store data
//   d_rdata/d_valid       : load data and one-cycle completion pulse
//   d_stall               : d_req & ~d_valid
//   mem_en/mem_addr       : memory strobe and address
//   mem_wr/mem_wdata      : memory byte enables and write data
//   mem_ready/mem_rdata   : memory accept handshake and read data
// -----------------------------------------------------------------------------
module unified_mem_arbiter #(
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_valid,
    output logic        if_stall,

    input  logic        d_req,
    input  logic [31:0] d_addr,
    input  logic [3:0]  d_wr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_valid,
    output logic        d_stall,

    output logic        mem_en,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    localparam logic [2:0] LAT_LOAD   = 3'(MEM_LAT - 1);
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_t      state, state_nxt;
    logic        owner_if, owner_if_nxt;     // 1 = fetch owns the transaction
    logic [2:0]  lat_cnt, lat_cnt_nxt;
    logic [3:0]  starve_cnt, starve_cnt_nxt;
    logic [31:0] addr_q, addr_nxt;
    logic [3:0]  wr_q, wr_nxt;
    logic [31:0] wdata_q, wdata_nxt;
    logic [31:0] rdata_q, rdata_nxt;
    logic        grant_if;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            owner_if   <= 1'b0;
            lat_cnt    <= 3'd0;
            starve_cnt <= 4'd0;
            addr_q     <= 32'd0;
            wr_q       <= 4'd0;
            wdata_q    <= 32'd0;
            rdata_q    <= 32'd0;
        end else begin
            state      <= state_nxt;
            owner_if   <= owner_if_nxt;
            lat_cnt    <= lat_cnt_nxt;
            starve_cnt <= starve_cnt_nxt;
            addr_q     <= addr_nxt;
            wr_q       <= wr_nxt;
            wdata_q    <= wdata_nxt;
            rdata_q    <= rdata_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        owner_if_nxt   = owner_if;
        lat_cnt_nxt    = lat_cnt;
        starve_cnt_nxt = starve_cnt;
        addr_nxt       = addr_q;
        wr_nxt         = wr_q;
        wdata_nxt      = wdata_q;
        rdata_nxt      = rdata_q;
        grant_if       = 1'b0;

        case (state)
            IDLE: begin
                if (if_req || d_req) begin
                    // Fetch wins when alone, or when contested and starved.
                    grant_if     = if_req && (!d_req || (starve_cnt == STARVE_LIM));
                    owner_if_nxt = grant_if;
                    state_nxt    = ISSUE;
                    if (grant_if) begin
                        addr_nxt       = if_addr;
                        wr_nxt         = 4'd0;
                        wdata_nxt      = 32'd0;
                        starve_cnt_nxt = 4'd0;
                    end else begin
                        addr_nxt  = d_addr;
                        wr_nxt    = d_wr;
                        wdata_nxt = d_wdata;
                        // Only a grant that leaves fetch waiting counts toward starvation.
                        if (if_req && (starve_cnt != STARVE_LIM)) begin
                            starve_cnt_nxt = starve_cnt + 4'd1;
                        end
                    end
                end
            end

            ISSUE: begin
                if (mem_ready) begin
                    if (wr_q != 4'd0) begin
                        state_nxt = RESP;
                    end else begin
                        lat_cnt_nxt = LAT_LOAD;
                        state_nxt   = WAIT;
                    end
                end
            end

            WAIT: begin
                if (lat_cnt == 3'd0) begin
                    rdata_nxt = mem_rdata;
                    state_nxt = RESP;
                end else begin
                    lat_cnt_nxt = lat_cnt - 3'd1;
                end
            end

            RESP: begin
                state_nxt = IDLE;
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Strobe and byte enables are only live while issuing; address and data
    // simply hold the last latched transaction.
    assign mem_en    = (state == ISSUE);
    assign mem_wr    = (state == ISSUE) ? wr_q : 4'd0;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    assign if_valid  = (state == RESP) && owner_if;
    assign d_valid   = (state == RESP) && !owner_if;
    assign if_rdata  = rdata_q;
    assign d_rdata   = rdata_q;

    assign if_stall  = if_req & ~if_valid;
    assign d_stall   = d_req & ~d_valid;

endmodule

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
- Shares one single-ported unified memory between the instruction-fetch port and the load/store port of the 32-bit RISC-V core.
- Sequences each access through issue, wait and response phases.
- Gives data accesses priority over fetch, with a starvation guard so fetch cannot be locked out.
- Sits between fetch/LSU and the memory macro; its stall outputs feed the fetch and LSU stall inputs.

Parameters:
MEM_LAT, 1, cycles from accepted read (mem_en & mem_ready) to mem_rdata valid; legal 1..7
STARVE_MAX, 4, consecutive data grants with if_req pending before fetch is forced; legal 1..15

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
if_req  in  1  fetch request, level; held until if_valid
if_addr  in  32  fetch address
if_rdata  out  32  read data to fetch, qualified by if_valid
if_valid  out  1  one-cycle completion pulse to fetch
if_stall  out  1  if_req & ~if_valid (combinational)
d_req  in  1  data request, level; held until d_valid
d_addr  in  32  data address
d_wr  in  4  byte write enables; 0 means read
d_wdata  in  32  store data
d_rdata  out  32  read data to LSU, qualified by d_valid
d_valid  out  1  one-cycle completion pulse to LSU
d_stall  out  1  d_req & ~d_valid (combinational)
mem_en  out  1  memory access strobe
mem_addr  out  32  memory address
mem_wr  out  4  memory byte write enables
mem_wdata  out  32  memory write data
mem_ready  in  1  memory accepts strobe this cycle
mem_rdata  in  32  memory read data

Behaviour:
- One clock, synchronous active-high reset.
- Reset values:
  - state = IDLE.
  - mem_en, mem_wr, if_valid, d_valid = 0.
  - mem_addr, mem_wdata, rdata register = 0.
  - owner = data; starve_cnt = 0; lat_cnt = 0.
- Reset asserted mid-transaction abandons it: no valid pulse, mem_en drops the next cycle.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Sample requests. If neither is asserted, stay in IDLE.
  - Otherwise pick an owner:
    - Only one request asserted: that requester wins.
    - Both asserted and starve_cnt == STARVE_MAX: fetch wins.
    - Both asserted otherwise: data wins.
  - Latch address, wr and wdata from the owner (fetch always has wr = 0), then go to ISSUE.
- ISSUE:
  - mem_en = 1; mem_addr/mem_wr/mem_wdata driven from the latched values.
  - Latched values are held stable while mem_ready = 0; no timeout.
  - On mem_ready = 1 with a write: go to RESP.
  - On mem_ready = 1 with a read: load lat_cnt = MEM_LAT - 1 and go to WAIT.
- WAIT:
  - mem_en = 0. Decrement lat_cnt each cycle.
  - In the cycle where lat_cnt == 0, capture mem_rdata into the rdata register and go to RESP.
  - With MEM_LAT = 1, WAIT lasts exactly one cycle and captures data in that cycle.
- RESP:
  - Owner's valid = 1 for exactly one cycle; the other valid stays 0. Then go to IDLE.
  - if_rdata and d_rdata both show the rdata register and hold it until the next capture.
  - For writes, the rdata register is unchanged.
- Latency from IDLE grant to valid:
  - Read: 2 + MEM_LAT cycles with mem_ready held high.
  - Write: 2 cycles.
- Requester rules:
  - A requester must hold req and its inputs stable until its valid.
  - It may keep req high in the cycle after valid to present a new access with new inputs; IDLE samples that as a fresh request.
  - Dropping req before valid is illegal and is not checked.
- Starvation counter:
  - Increments when data is granted while if_req = 1; saturates at STARVE_MAX.
  - Clears on any fetch grant.
  - Unchanged on a data grant with if_req = 0.
- Simultaneous events: a request arriving during ISSUE/WAIT/RESP waits for IDLE; at most one transaction is outstanding.
- Address and data pass through unmodified; byte-lane alignment is the LSU's responsibility.

Test Plan:
- Reset, then single fetch with if_addr = 0x0000_0010, MEM_LAT = 1, mem_ready = 1, mem_rdata = 0x0051_0093 -> mem_en high 1 cycle with mem_addr = 0x10; if_valid pulses 3 cycles after grant; if_rdata = 0x0051_0093; d_valid stays 0.
- Data store d_addr = 0x100, d_wr = 0xF, d_wdata = 0xDEAD_BEEF -> mem_wr = 0xF, mem_wdata = 0xDEAD_BEEF for one cycle; d_valid pulses 2 cycles after grant; rdata register unchanged.
- if_req and d_req held together continuously, STARVE_MAX = 4 -> grant order D, D, D, D, I, D, D, D, D, I; no cycle where both valids are high.
- mem_ready low for 5 cycles during ISSUE of a load to 0x200 -> mem_en and mem_addr = 0x200 stable all 6 cycles; d_valid arrives 5 cycles later than the no-stall case.
- MEM_LAT = 3 read, mem_rdata = 0x1234_5678 presented only 3 cycles after acceptance -> d_rdata = 0x1234_5678; other mem_rdata values are ignored.
- rst asserted during WAIT of a fetch -> next cycle state IDLE, mem_en = 0, starve_cnt = 0; no if_valid pulse ever appears for that fetch.
